// File: rtl/core_dmem_responder.sv
// Memory-side responder for the core dmem request/grant/response port.
// Word-addressed 64-bit RAM at BASE_ADDR, programmable wait states, single-cycle response.
module core_dmem_responder #(
  parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_0001_0000,
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        dmem_req,
  input  logic [63:0] dmem_addr,
  input  logic        dmem_wen,
  input  logic [7:0]  dmem_strb,
  input  logic [63:0] dmem_wdata,
  input  logic        dmem_stall,
  output logic        dmem_gnt,
  output logic        dmem_err,
  output logic [63:0] dmem_rdata,
  output logic        dmem_rvalid
);

  localparam int          IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [63:0] SPAN     = 64'(DEPTH) * 64'd8;
  localparam logic [3:0]  WAIT_MAX = 4'(WAIT_CYCLES);

  generate
    if (BASE_ADDR[2:0] != 3'd0) begin : g_bad_base
      $error("core_dmem_responder: BASE_ADDR must be 8-byte aligned");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("core_dmem_responder: DEPTH must be a power of two >= 2");
    end
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("core_dmem_responder: WAIT_CYCLES must be in 0..15");
    end
  endgenerate

  logic [3:0]       wait_cnt_q, wait_cnt_d;
  logic             rvalid_q;
  logic             err_q;
  logic [63:0]      rdata_q;
  logic [63:0]      mem_q [DEPTH];

  logic [63:0]      addr_off;
  logic             in_range;
  logic [IDX_W-1:0] word_idx;
  logic             wr_en;

  // Offset compare avoids overflow of BASE_ADDR+SPAN near the top of the address space.
  assign addr_off = dmem_addr - BASE_ADDR;
  assign in_range = (dmem_addr >= BASE_ADDR) && (addr_off < SPAN);
  assign word_idx = addr_off[3 +: IDX_W];

  assign dmem_gnt = g_resetn && dmem_req && !dmem_stall && (wait_cnt_q == WAIT_MAX);
  assign wr_en    = dmem_gnt && dmem_wen && in_range;

  // Stall pauses the count so every stalled cycle adds exactly one cycle of latency.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!dmem_req || dmem_gnt) begin
      wait_cnt_d = 4'd0;
    end else if (!dmem_stall && (wait_cnt_q < WAIT_MAX)) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      wait_cnt_q <= 4'd0;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= 64'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      if (dmem_gnt) begin
        rvalid_q <= 1'b1;
        err_q    <= !in_range;
        rdata_q  <= (!dmem_wen && in_range) ? mem_q[word_idx] : 64'd0;
      end else begin
        rvalid_q <= 1'b0;
        err_q    <= 1'b0;
      end
    end
  end

  // RAM contents are deliberately left out of reset.
  always_ff @(posedge g_clk) begin
    if (wr_en) begin
      for (int b = 0; b < 8; b++) begin
        if (dmem_strb[b]) begin
          mem_q[word_idx][b*8 +: 8] <= dmem_wdata[b*8 +: 8];
        end
      end
    end
  end

  assign dmem_rvalid = rvalid_q;
  assign dmem_err    = err_q;
  assign dmem_rdata  = rdata_q;

endmodule

// File: tb/tb_core_dmem_responder.sv
// Directed bench for core_dmem_responder: one zero-wait instance and one
// three-wait-state instance sharing clock, reset and request attributes.
module tb_core_dmem_responder;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [63:0] addr = 64'd0;
  logic        wen = 1'b0;
  logic [7:0]  strb = 8'd0;
  logic [63:0] wdata = 64'd0;

  logic        req0 = 1'b0, stall0 = 1'b0;
  logic        gnt0, err0, rvalid0;
  logic [63:0] rdata0;
  logic        req3 = 1'b0, stall3 = 1'b0;
  logic        gnt3, err3, rvalid3;
  logic [63:0] rdata3;

  int checks = 0;
  int failures = 0;

  localparam logic [63:0] D_FULL = 64'h1122334455667788;
  localparam logic [63:0] D_W3   = 64'h0F1E2D3C4B5A6978;

  always #5 clk = ~clk;

  core_dmem_responder #(.BASE_ADDR(64'h10000), .DEPTH(1024), .WAIT_CYCLES(0)) dut0 (
    .g_clk(clk), .g_resetn(resetn), .dmem_req(req0), .dmem_addr(addr), .dmem_wen(wen),
    .dmem_strb(strb), .dmem_wdata(wdata), .dmem_stall(stall0), .dmem_gnt(gnt0),
    .dmem_err(err0), .dmem_rdata(rdata0), .dmem_rvalid(rvalid0)
  );

  core_dmem_responder #(.BASE_ADDR(64'h10000), .DEPTH(1024), .WAIT_CYCLES(3)) dut3 (
    .g_clk(clk), .g_resetn(resetn), .dmem_req(req3), .dmem_addr(addr), .dmem_wen(wen),
    .dmem_strb(strb), .dmem_wdata(wdata), .dmem_stall(stall3), .dmem_gnt(gnt3),
    .dmem_err(err3), .dmem_rdata(rdata3), .dmem_rvalid(rvalid3)
  );

  task automatic drive(input int which, input logic [63:0] a, input logic w,
                       input logic [7:0] s, input logic [63:0] d);
    addr = a; wen = w; strb = s; wdata = d;
    if (which == 0) req0 = 1'b1; else req3 = 1'b1;
    $display("txn dut%0d %s addr=%h strb=%h wdata=%h", which == 0 ? 0 : 3,
             w ? "WR" : "RD", a, s, d);
  endtask

  task automatic idle();
    req0 = 1'b0; req3 = 1'b0; stall0 = 1'b0; stall3 = 1'b0;
    wen = 1'b0; strb = 8'd0;
  endtask

  task automatic test_reset();
    drive(0, 64'h10008, 1'b0, 8'h00, 64'd0);
    req3 = 1'b1;
    @(negedge clk); @(negedge clk);
    #1;
    checks++; if (gnt0 !== 1'b0) begin failures++; $display("FAIL rst_gnt0 got=%b exp=0", gnt0); end
    checks++; if (gnt3 !== 1'b0) begin failures++; $display("FAIL rst_gnt3 got=%b exp=0", gnt3); end
    checks++; if (rvalid0 !== 1'b0) begin failures++; $display("FAIL rst_rvalid got=%b exp=0", rvalid0); end
    checks++; if (err0 !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", err0); end
    checks++; if (rdata0 !== 64'd0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", rdata0); end
    @(negedge clk);
    idle();
    resetn = 1'b1;
  endtask

  task automatic test_write_read();
    @(negedge clk);
    drive(0, 64'h10008, 1'b1, 8'hFF, D_FULL);
    #1;
    checks++; if (gnt0 !== 1'b1) begin failures++; $display("FAIL wr_gnt got=%b exp=1", gnt0); end
    @(negedge clk);
    checks++; if (rvalid0 !== 1'b1) begin failures++; $display("FAIL wr_rvalid got=%b exp=1", rvalid0); end
    checks++; if (rdata0 !== 64'd0) begin failures++; $display("FAIL wr_rdata got=%h exp=0", rdata0); end
    drive(0, 64'h10008, 1'b0, 8'h00, 64'd0);
    #1;
    checks++; if (gnt0 !== 1'b1) begin failures++; $display("FAIL rd_gnt got=%b exp=1", gnt0); end
    @(negedge clk);
    checks++; if (rvalid0 !== 1'b1) begin failures++; $display("FAIL rd_rvalid got=%b exp=1", rvalid0); end
    checks++; if (rdata0 !== D_FULL) begin failures++; $display("FAIL rd_rdata got=%h exp=%h", rdata0, D_FULL); end
    checks++; if (err0 !== 1'b0) begin failures++; $display("FAIL rd_err got=%b exp=0", err0); end
    idle();
    @(negedge clk);
    checks++; if (rvalid0 !== 1'b0) begin failures++; $display("FAIL idle_rvalid got=%b exp=0", rvalid0); end
    checks++; if (rdata0 !== D_FULL) begin failures++; $display("FAIL idle_rdata_hold got=%h exp=%h", rdata0, D_FULL); end
  endtask

  task automatic test_strobes();
    drive(0, 64'h10010, 1'b1, 8'hFF, 64'd0);
    @(negedge clk);
    drive(0, 64'h10010, 1'b1, 8'h0F, 64'hAAAAAAAA_BBBBBBBB);
    @(negedge clk);
    drive(0, 64'h10010, 1'b0, 8'h00, 64'd0);
    @(negedge clk);
    checks++; if (rdata0 !== 64'h00000000_BBBBBBBB) begin failures++; $display("FAIL strb_partial got=%h exp=00000000bbbbbbbb", rdata0); end
    drive(0, 64'h10010, 1'b1, 8'h00, 64'hFFFFFFFF_FFFFFFFF);
    #1;
    checks++; if (gnt0 !== 1'b1) begin failures++; $display("FAIL strb0_gnt got=%b exp=1", gnt0); end
    @(negedge clk);
    checks++; if (rvalid0 !== 1'b1 || err0 !== 1'b0) begin failures++; $display("FAIL strb0_resp got=rv%b/err%b exp=rv1/err0", rvalid0, err0); end
    drive(0, 64'h10010, 1'b0, 8'h00, 64'd0);
    @(negedge clk);
    checks++; if (rdata0 !== 64'h00000000_BBBBBBBB) begin failures++; $display("FAIL strb0_unchanged got=%h exp=00000000bbbbbbbb", rdata0); end
    idle();
    @(negedge clk);
  endtask

  task automatic test_out_of_range();
    drive(0, 64'h10000, 1'b1, 8'hFF, 64'hCAFEF00D_12345678);
    @(negedge clk);
    drive(0, 64'h10000, 1'b0, 8'h00, 64'd0);
    @(negedge clk);
    drive(0, 64'h0, 1'b0, 8'h00, 64'd0);
    @(negedge clk);
    checks++; if (rvalid0 !== 1'b1 || err0 !== 1'b1) begin failures++; $display("FAIL oor_rd_err got=rv%b/err%b exp=rv1/err1", rvalid0, err0); end
    checks++; if (rdata0 !== 64'd0) begin failures++; $display("FAIL oor_rd_rdata got=%h exp=0", rdata0); end
    drive(0, 64'h12000, 1'b1, 8'hFF, 64'hDEADBEEF_DEADBEEF);
    @(negedge clk);
    checks++; if (err0 !== 1'b1) begin failures++; $display("FAIL oor_wr_err got=%b exp=1", err0); end
    drive(0, 64'h11FF8, 1'b1, 8'hFF, 64'h01234567_89ABCDEF);
    @(negedge clk);
    checks++; if (err0 !== 1'b0) begin failures++; $display("FAIL last_word_err got=%b exp=0", err0); end
    drive(0, 64'h10000, 1'b0, 8'h00, 64'd0);
    @(negedge clk);
    checks++; if (rdata0 !== 64'hCAFEF00D_12345678) begin failures++; $display("FAIL oor_ram_kept got=%h exp=cafef00d12345678", rdata0); end
    drive(0, 64'h11FF8, 1'b0, 8'h00, 64'd0);
    @(negedge clk);
    checks++; if (rdata0 !== 64'h01234567_89ABCDEF || err0 !== 1'b0) begin failures++; $display("FAIL last_word_rd got=%h/err%b exp=0123456789abcdef/err0", rdata0, err0); end
    idle();
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [63:0] vals [4];
    vals[0] = 64'hA0A0_0000_0000_0001;
    vals[1] = 64'hB1B1_0000_0000_0002;
    vals[2] = 64'hC2C2_0000_0000_0003;
    vals[3] = 64'hD3D3_0000_0000_0004;
    for (int i = 0; i < 4; i++) begin
      drive(0, 64'h10020 + 64'(i) * 64'd8, 1'b1, 8'hFF, vals[i]);
      @(negedge clk);
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        checks++; if (rvalid0 !== 1'b1) begin failures++; $display("FAIL b2b_rvalid[%0d] got=%b exp=1", i - 1, rvalid0); end
        checks++; if (rdata0 !== vals[i-1]) begin failures++; $display("FAIL b2b_rdata[%0d] got=%h exp=%h", i - 1, rdata0, vals[i-1]); end
      end
      if (i < 4) begin
        drive(0, 64'h10020 + 64'(i) * 64'd8, 1'b0, 8'h00, 64'd0);
        #1;
        checks++; if (gnt0 !== 1'b1) begin failures++; $display("FAIL b2b_gnt[%0d] got=%b exp=1", i, gnt0); end
        @(negedge clk);
      end else begin
        idle();
      end
    end
    @(negedge clk);
  endtask

  task automatic test_wait_withdraw();
    drive(3, 64'h10008, 1'b1, 8'hFF, D_W3);
    #1;
    checks++; if (gnt3 !== 1'b0) begin failures++; $display("FAIL wd_gnt_c0 got=%b exp=0", gnt3); end
    @(negedge clk);
    #1;
    checks++; if (gnt3 !== 1'b0) begin failures++; $display("FAIL wd_gnt_c1 got=%b exp=0", gnt3); end
    @(negedge clk);
    req3 = 1'b0;
    @(negedge clk);
    checks++; if (rvalid3 !== 1'b0) begin failures++; $display("FAIL wd_no_resp got=%b exp=0", rvalid3); end
    drive(3, 64'h10008, 1'b1, 8'hFF, D_W3);
    for (int c = 0; c < 4; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      checks++; if (gnt3 !== (c == 3)) begin failures++; $display("FAIL w3_gnt_c%0d got=%b exp=%b", c, gnt3, c == 3); end
    end
    @(negedge clk);
    checks++; if (rvalid3 !== 1'b1 || err3 !== 1'b0) begin failures++; $display("FAIL w3_resp got=rv%b/err%b exp=rv1/err0", rvalid3, err3); end
    idle();
    @(negedge clk);
  endtask

  task automatic test_wait_stall();
    drive(3, 64'h10008, 1'b0, 8'h00, 64'd0);
    for (int c = 0; c < 6; c++) begin
      if (c != 0) @(negedge clk);
      stall3 = (c == 1 || c == 2);
      #1;
      checks++; if (gnt3 !== (c == 5)) begin failures++; $display("FAIL stall_gnt_c%0d got=%b exp=%b", c, gnt3, c == 5); end
    end
    @(negedge clk);
    checks++; if (rvalid3 !== 1'b1) begin failures++; $display("FAIL stall_rvalid got=%b exp=1", rvalid3); end
    checks++; if (rdata3 !== D_W3) begin failures++; $display("FAIL stall_rdata got=%h exp=%h", rdata3, D_W3); end
    idle();
    @(negedge clk);
    checks++; if (rvalid3 !== 1'b0) begin failures++; $display("FAIL stall_rvalid_drop got=%b exp=0", rvalid3); end
  endtask

  task automatic test_reset_wait();
    drive(3, 64'h10008, 1'b0, 8'h00, 64'd0);
    @(negedge clk);
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    checks++; if (gnt3 !== 1'b0) begin failures++; $display("FAIL rstw_gnt got=%b exp=0", gnt3); end
    @(negedge clk);
    resetn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      checks++; if (gnt3 !== (c == 3)) begin failures++; $display("FAIL rstw_gnt_c%0d got=%b exp=%b", c, gnt3, c == 3); end
    end
    @(negedge clk);
    checks++; if (rdata3 !== D_W3) begin failures++; $display("FAIL rstw_rdata got=%h exp=%h", rdata3, D_W3); end
    idle();
    @(negedge clk);
  endtask

  task automatic test_reset_response();
    drive(0, 64'h10008, 1'b0, 8'h00, 64'd0);
    @(negedge clk);
    checks++; if (rvalid0 !== 1'b1 || rdata0 !== D_FULL) begin failures++; $display("FAIL rstr_pre got=rv%b/%h exp=rv1/%h", rvalid0, rdata0, D_FULL); end
    idle();
    #2 resetn = 1'b0;
    #1;
    checks++; if (rvalid0 !== 1'b0) begin failures++; $display("FAIL rstr_rvalid got=%b exp=0", rvalid0); end
    checks++; if (rdata0 !== 64'd0) begin failures++; $display("FAIL rstr_rdata got=%h exp=0", rdata0); end
    checks++; if (err0 !== 1'b0) begin failures++; $display("FAIL rstr_err got=%b exp=0", err0); end
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    drive(0, 64'h10008, 1'b0, 8'h00, 64'd0);
    #1;
    checks++; if (gnt0 !== 1'b1) begin failures++; $display("FAIL rstr_gnt got=%b exp=1", gnt0); end
    @(negedge clk);
    checks++; if (rdata0 !== D_FULL) begin failures++; $display("FAIL rstr_persist got=%h exp=%h", rdata0, D_FULL); end
    idle();
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_strobes();
    test_out_of_range();
    test_back_to_back();
    test_wait_withdraw();
    test_wait_stall();
    test_reset_wait();
    test_reset_response();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
